// File: rtl/ysyx_040729_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_040729_pkg
//   Shared definitions for the core-local interruptor (CLINT).
//   - CLINT register offsets inside the 64 KiB CLINT window
//   - register-select type used by the address decoder
//   - byte-strobe merge helper used by every writable 64-bit register
//   Optional feature macro used by the CLINT: CLINT_MSIP_EN.
// -----------------------------------------------------------------------------
package ysyx_040729_pkg;

   // Register offsets; all registers are 8-byte aligned.
   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

   // Which register an (aligned) offset selects.
   typedef enum logic [1:0] {
      SEL_NONE     = 2'd0,
      SEL_MSIP     = 2'd1,
      SEL_MTIMECMP = 2'd2,
      SEL_MTIME    = 2'd3
   } clint_sel_e;

   // Byte-lane merge: lanes whose strobe bit is set take new_val,
   // all other lanes keep old_val.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  wstrb);
      logic [63:0] res;
      res = old_val;
      for (int i = 0; i < 8; i++) begin
         if (wstrb[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage : ysyx_040729_pkg

// File: rtl/ysyx_040729_clint_if.sv
// -----------------------------------------------------------------------------
// ysyx_040729_clint_if
//   Simple request/response bus between the LSU (master) and the CLINT (slave).
//
//   Handshake: a request is transferred on every rising clk edge where req is
//   high; there is no ready signal, the slave accepts unconditionally. Exactly
//   one response follows each accepted request: resp_valid is high for one
//   cycle, one cycle after the accepting edge, and rdata is meaningful only
//   while resp_valid is high (reads: register value, writes: zero).
//
//   Signals
//     req        master->slave  request valid
//     wen        master->slave  1 = write, 0 = read (qualified by req)
//     addr       master->slave  byte offset within the CLINT window
//     wdata      master->slave  write data
//     wstrb      master->slave  byte write strobes
//     rdata      slave->master  read data
//     resp_valid slave->master  one-cycle response pulse
// -----------------------------------------------------------------------------
interface ysyx_040729_clint_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 64
);

   logic                  req;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [7:0]            wstrb;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  resp_valid;

   modport master (
      output req, wen, addr, wdata, wstrb,
      input  rdata, resp_valid
   );

   modport slave (
      input  req, wen, addr, wdata, wstrb,
      output rdata, resp_valid
   );

endinterface : ysyx_040729_clint_if

// File: rtl/ysyx_040729_clint_prescaler.sv
// -----------------------------------------------------------------------------
// ysyx_040729_clint_prescaler
//   Tick generator for mtime. A counter runs 0..TICK_DIV-1; tick is high in the
//   cycle the counter holds TICK_DIV-1, and at that edge the counter wraps to 0.
//   With TICK_DIV=1 the counter is pinned at 0 and tick is high every cycle.
//
//   Parameters
//     TICK_DIV  clk cycles per tick, legal range 1..65535
//   Ports
//     clk   in   system clock, rising edge
//     rst   in   asynchronous active-low reset
//     tick  out  one tick per TICK_DIV cycles (combinational from the counter)
// -----------------------------------------------------------------------------
module ysyx_040729_clint_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule : ysyx_040729_clint_prescaler

// File: rtl/ysyx_040729_clint.sv
// -----------------------------------------------------------------------------
// ysyx_040729_clint
//   Core-local interruptor. Holds a free-running 64-bit mtime and a 64-bit
//   mtimecmp, both memory-mapped on the LSU request/response bus, and drives
//   the registered machine timer interrupt tirp_o = (mtime >= mtimecmp).
//
//   Register map (aligned offset, addr[2:0] ignored)
//     0x0000  msip      bit 0 only (present with CLINT_MSIP_EN, else unmapped)
//     0x4000  mtimecmp
//     0xBFF8  mtime
//   Unmapped offsets read as 0 and ignore writes; they still get a response.
//
//   Optional feature macro: CLINT_MSIP_EN adds the msip register and sirp_o.
//
//   Parameters
//     DATA_WIDTH  bus data width (64)
//     TICK_DIV    clk cycles per mtime increment, 1..65535
//     ADDR_WIDTH  offset width within the CLINT window (>= 16)
//   Ports
//     clk     in     system clock, rising edge
//     rst     in     asynchronous active-low reset
//     bus     slave  request/response bus (see ysyx_040729_clint_if)
//     tirp_o  out    timer interrupt pending (level), to CSR tirp_i
//     sirp_o  out    software interrupt pending (CLINT_MSIP_EN only)
// -----------------------------------------------------------------------------
module ysyx_040729_clint
   import ysyx_040729_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TICK_DIV   = 1,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   ysyx_040729_clint_if.slave         bus,
   output logic                       tirp_o
`ifdef CLINT_MSIP_EN
   ,
   output logic                       sirp_o
`endif
);

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] off;
   logic [2:0]            unused_addr_lsbs;
   clint_sel_e            sel;

   assign off              = {bus.addr[ADDR_WIDTH-1:3], 3'b000};
   assign unused_addr_lsbs = bus.addr[2:0];

   always_comb begin
      sel = SEL_NONE;
      if (off == ADDR_WIDTH'(CLINT_MTIMECMP_OFF)) begin
         sel = SEL_MTIMECMP;
      end else if (off == ADDR_WIDTH'(CLINT_MTIME_OFF)) begin
         sel = SEL_MTIME;
`ifdef CLINT_MSIP_EN
      end else if (off == ADDR_WIDTH'(CLINT_MSIP_OFF)) begin
         sel = SEL_MSIP;
`endif
      end
   end

   logic        wr;
   logic        rd;
   logic [63:0] wdata64;

   assign wr      = bus.req &  bus.wen;
   assign rd      = bus.req & ~bus.wen;
   assign wdata64 = 64'(bus.wdata);

   // ---------------------------------------------------------------------------
   // mtime: prescaled free-running counter
   // ---------------------------------------------------------------------------
   logic        tick;
   logic [63:0] mtime_q;
   logic [63:0] mtime_inc;

   ysyx_040729_clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Wraps from all-ones to zero silently.
   assign mtime_inc = tick ? (mtime_q + 64'd1) : mtime_q;

   // A write coinciding with a tick merges into the incremented value, so
   // unwritten lanes still advance. The prescaler is never disturbed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_q <= '0;
      end else if (wr && (sel == SEL_MTIME)) begin
         mtime_q <= strb_merge(mtime_inc, wdata64, bus.wstrb);
      end else begin
         mtime_q <= mtime_inc;
      end
   end

   // ---------------------------------------------------------------------------
   // mtimecmp
   // ---------------------------------------------------------------------------
   logic [63:0] mtimecmp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtimecmp_q <= '1;
      end else if (wr && (sel == SEL_MTIMECMP)) begin
         mtimecmp_q <= strb_merge(mtimecmp_q, wdata64, bus.wstrb);
      end
   end

   // ---------------------------------------------------------------------------
   // msip (optional)
   // ---------------------------------------------------------------------------
`ifdef CLINT_MSIP_EN
   logic msip_q;
   logic sirp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msip_q <= 1'b0;
      end else if (wr && (sel == SEL_MSIP) && bus.wstrb[0]) begin
         msip_q <= bus.wdata[0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sirp_q <= 1'b0;
      end else begin
         sirp_q <= msip_q;
      end
   end

   assign sirp_o = sirp_q;
`endif

   // ---------------------------------------------------------------------------
   // Read mux: samples register values as they are before the accepting edge.
   // ---------------------------------------------------------------------------
   logic [63:0] rd_val;

   always_comb begin
      rd_val = '0;
      case (sel)
         SEL_MTIMECMP: rd_val = mtimecmp_q;
         SEL_MTIME:    rd_val = mtime_q;
`ifdef CLINT_MSIP_EN
         SEL_MSIP:     rd_val = {63'd0, msip_q};
`endif
         default:      rd_val = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Response register: one response per accepted request, never stalled.
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  resp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         rdata_q <= rd ? DATA_WIDTH'(rd_val) : '0;
         resp_q  <= bus.req;
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.resp_valid = resp_q;

   // ---------------------------------------------------------------------------
   // Timer interrupt: registered unsigned compare of the current registers.
   // ---------------------------------------------------------------------------
   logic tirp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tirp_q <= 1'b0;
      end else begin
         tirp_q <= (mtime_q >= mtimecmp_q);
      end
   end

   assign tirp_o = tirp_q;

endmodule : ysyx_040729_clint

// File: tb/tb_ysyx_040729_clint.sv
// -----------------------------------------------------------------------------
// tb_ysyx_040729_clint
//   Two CLINT instances share clock and reset: dut0 with TICK_DIV=1 and dut1
//   with TICK_DIV=4. The reference model describes mtime arithmetically: after
//   the k-th clock edge since reset release, mtime equals the value last
//   anchored by a write plus the number of ticks (k / TICK_DIV steps) elapsed
//   since that write. Registered outputs after edge k are derived from the
//   model state as it stood after edge k-1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_040729_clint;

   localparam int unsigned TD0 = 1;
   localparam int unsigned TD1 = 4;

   localparam logic [15:0] A_MSIP  = 16'h0000;
   localparam logic [15:0] A_CMP   = 16'h4000;
   localparam logic [15:0] A_MTIME = 16'hBFF8;
   localparam logic [15:0] A_HOLE  = 16'h8000;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------------
   ysyx_040729_clint_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus0 ();
   ysyx_040729_clint_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus1 ();

   logic tirp0;
   logic tirp1;
`ifdef CLINT_MSIP_EN
   logic sirp0;
   logic sirp1;
`endif

   ysyx_040729_clint #(.DATA_WIDTH(64), .TICK_DIV(TD0), .ADDR_WIDTH(16)) dut0 (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus0),
      .tirp_o (tirp0)
`ifdef CLINT_MSIP_EN
      ,
      .sirp_o (sirp0)
`endif
   );

   ysyx_040729_clint #(.DATA_WIDTH(64), .TICK_DIV(TD1), .ADDR_WIDTH(16)) dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus1),
      .tirp_o (tirp1)
`ifdef CLINT_MSIP_EN
      ,
      .sirp_o (sirp1)
`endif
   );

   // ---------------------------------------------------------------------------
   // Driven inputs
   // ---------------------------------------------------------------------------
   logic        b_req   [2];
   logic        b_wen   [2];
   logic [15:0] b_addr  [2];
   logic [63:0] b_wdata [2];
   logic [7:0]  b_wstrb [2];

   assign bus0.req   = b_req[0];
   assign bus0.wen   = b_wen[0];
   assign bus0.addr  = b_addr[0];
   assign bus0.wdata = b_wdata[0];
   assign bus0.wstrb = b_wstrb[0];
   assign bus1.req   = b_req[1];
   assign bus1.wen   = b_wen[1];
   assign bus1.addr  = b_addr[1];
   assign bus1.wdata = b_wdata[1];
   assign bus1.wstrb = b_wstrb[1];

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   longint      k;               // clock edges since reset release
   logic [63:0] anc_val [2];     // mtime value fixed by the latest write (or reset)
   longint      anc_k   [2];     // edge at which that value was fixed
   logic [63:0] m_cmp   [2];
   logic [63:0] e_rdata [2];
   logic        e_resp  [2];
   logic        e_tirp  [2];
`ifdef CLINT_MSIP_EN
   logic        m_msip  [2];
   logic        e_sirp  [2];
`endif

   int n_checks = 0;
   int n_errors = 0;

   function automatic longint tdiv(input int d);
      return (d == 0) ? longint'(TD0) : longint'(TD1);
   endfunction

   // mtime after edge 'at', assuming no write after the anchor.
   function automatic logic [63:0] model_mtime(input int d, input longint at);
      return anc_val[d] + 64'((at / tdiv(d)) - (anc_k[d] / tdiv(d)));
   endfunction

   function automatic logic [63:0] byte_mask(input logic [7:0] s);
      logic [63:0] m;
      m = 64'd0;
      for (int i = 0; i < 8; i++) begin
         if (s[i]) m = m | (64'hFF << (8 * i));
      end
      return m;
   endfunction

   function automatic logic [63:0] model_read(input int d, input logic [15:0] a, input longint at);
      logic [15:0] o;
      o = a & 16'hFFF8;
      if (o == A_CMP)   return m_cmp[d];
      if (o == A_MTIME) return model_mtime(d, at);
`ifdef CLINT_MSIP_EN
      if (o == A_MSIP)  return {63'd0, m_msip[d]};
`endif
      return 64'd0;
   endfunction

   task automatic model_write(input int d);
      logic [15:0] o;
      logic [63:0] msk;
      o   = b_addr[d] & 16'hFFF8;
      msk = byte_mask(b_wstrb[d]);
      if (o == A_MTIME) begin
         anc_val[d] = (model_mtime(d, k) & ~msk) | (b_wdata[d] & msk);
         anc_k[d]   = k;
      end else if (o == A_CMP) begin
         m_cmp[d] = (m_cmp[d] & ~msk) | (b_wdata[d] & msk);
      end
`ifdef CLINT_MSIP_EN
      else if (o == A_MSIP && b_wstrb[d][0]) begin
         m_msip[d] = b_wdata[d][0];
      end
`endif
   endtask

   task automatic reset_model();
      k = 0;
      for (int d = 0; d < 2; d++) begin
         anc_val[d] = 64'd0;
         anc_k[d]   = 0;
         m_cmp[d]   = '1;
         b_req[d]   = 1'b0;
         b_wen[d]   = 1'b0;
         b_addr[d]  = 16'd0;
         b_wdata[d] = 64'd0;
         b_wstrb[d] = 8'd0;
`ifdef CLINT_MSIP_EN
         m_msip[d]  = 1'b0;
`endif
      end
   endtask

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic check_all();
      chk("resp0",  64'(bus0.resp_valid), 64'(e_resp[0]));
      chk("rdata0", bus0.rdata,           e_rdata[0]);
      chk("tirp0",  64'(tirp0),           64'(e_tirp[0]));
      chk("resp1",  64'(bus1.resp_valid), 64'(e_resp[1]));
      chk("rdata1", bus1.rdata,           e_rdata[1]);
      chk("tirp1",  64'(tirp1),           64'(e_tirp[1]));
`ifdef CLINT_MSIP_EN
      chk("sirp0",  64'(sirp0),           64'(e_sirp[0]));
      chk("sirp1",  64'(sirp1),           64'(e_sirp[1]));
`endif
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_resp0"},  64'(bus0.resp_valid), 64'd0);
      chk({tag, "_rdata0"}, bus0.rdata,           64'd0);
      chk({tag, "_tirp0"},  64'(tirp0),           64'd0);
      chk({tag, "_resp1"},  64'(bus1.resp_valid), 64'd0);
      chk({tag, "_rdata1"}, bus1.rdata,           64'd0);
      chk({tag, "_tirp1"},  64'(tirp1),           64'd0);
`ifdef CLINT_MSIP_EN
      chk({tag, "_sirp0"},  64'(sirp0),           64'd0);
      chk({tag, "_sirp1"},  64'(sirp1),           64'd0);
`endif
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // One clock edge: update the model with the request present at the edge,
   // then sample the DUT outputs 1 ns later.
   task automatic step();
      @(posedge clk);
      k++;
      for (int d = 0; d < 2; d++) begin
         e_tirp[d]  = (model_mtime(d, k - 1) >= m_cmp[d]);
         e_resp[d]  = b_req[d];
         e_rdata[d] = (b_req[d] && !b_wen[d]) ? model_read(d, b_addr[d], k - 1) : 64'd0;
`ifdef CLINT_MSIP_EN
         e_sirp[d]  = m_msip[d];
`endif
         if (b_req[d] && b_wen[d]) model_write(d);
      end
      #1;
      check_all();
   endtask

   task automatic op(input int d, input logic w, input logic [15:0] a,
                     input logic [63:0] wd, input logic [7:0] s);
      b_req[d]   = 1'b1;
      b_wen[d]   = w;
      b_addr[d]  = a;
      b_wdata[d] = wd;
      b_wstrb[d] = s;
      step();
      b_req[d]   = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [15:0] base;
      int          guard;

      reset_model();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;                         // next rising edge is edge 1

      // Free-running mtime after reset, first response timing.
      repeat (10) step();
      op(0, 1'b0, A_MTIME, 64'd0, 8'h00);
      chk("t1_mtime_at10", bus0.rdata, 64'd10);
      chk("t1_resp",       64'(bus0.resp_valid), 64'd1);
      chk("t1_tirp",       64'(tirp0), 64'd0);
      step();
      chk("t1_resp_pulse", 64'(bus0.resp_valid), 64'd0);

      // Timer interrupt assert/deassert timing.
      op(0, 1'b1, A_CMP, 64'h20, 8'hFF);
      guard = 0;
      while (model_mtime(0, k) != 64'h20 && guard < 100) begin
         step();
         guard++;
      end
      chk("t2_tirp_before", 64'(tirp0), 64'd0);
      step();
      chk("t2_tirp_rise",   64'(tirp0), 64'd1);
      op(0, 1'b1, A_CMP, 64'hFFFF, 8'hFF);
      chk("t2_tirp_hold",   64'(tirp0), 64'd1);
      step();
      chk("t2_tirp_fall",   64'(tirp0), 64'd0);

      // Partial mtime write coinciding with a tick.
      op(0, 1'b1, A_MTIME, 64'h1_0000_0000, 8'hFF);
      repeat (5) step();
      op(0, 1'b1, A_MTIME, 64'h1234_5678_DEAD_BEEF, 8'h0F);
      op(0, 1'b0, A_MTIME, 64'd0, 8'h00);
      chk("t3_partial", bus0.rdata, 64'h0000_0001_DEAD_BEEF);

      // mtime wrap and tirp tracking it.
      op(0, 1'b1, A_CMP, 64'h10, 8'hFF);
      op(0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      step();
      chk("t4_tirp_pre_wrap",  64'(tirp0), 64'd1);
      step();
      step();
      chk("t4_tirp_post_wrap", 64'(tirp0), 64'd0);
      op(0, 1'b0, A_MTIME, 64'd0, 8'h00);
      chk("t4_wrap_value", bus0.rdata, 64'd1);

      // Divided tick and unmapped offsets on dut1.
      for (int i = 0; i < 9; i++) op(1, 1'b0, A_MTIME, 64'd0, 8'h00);
      op(1, 1'b0, A_HOLE, 64'd0, 8'h00);
      chk("t5_hole_rd",   bus1.rdata, 64'd0);
      chk("t5_hole_resp", 64'(bus1.resp_valid), 64'd1);
      op(1, 1'b1, A_HOLE, '1, 8'hFF);
      chk("t5_hole_wr_rdata", bus1.rdata, 64'd0);
      op(1, 1'b0, A_CMP, 64'd0, 8'h00);
      chk("t5_cmp_kept", bus1.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      op(1, 1'b0, A_MTIME, 64'd0, 8'h00);

      // Software interrupt (or unmapped offset 0 without the feature).
      op(0, 1'b1, A_MSIP, 64'h1, 8'h01);
`ifdef CLINT_MSIP_EN
      chk("t6_sirp_before", 64'(sirp0), 64'd0);
      step();
      chk("t6_sirp_rise",   64'(sirp0), 64'd1);
      op(0, 1'b0, A_MSIP, 64'd0, 8'h00);
      chk("t6_msip_rd",     bus0.rdata, 64'd1);
      op(1, 1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
`else
      op(0, 1'b0, A_MSIP, 64'd0, 8'h00);
      chk("t6_msip_absent", bus0.rdata, 64'd0);
`endif

      // Asynchronous reset in the middle of traffic with outputs active.
      op(0, 1'b1, A_CMP, 64'd0, 8'hFF);
      op(1, 1'b1, A_CMP, 64'd0, 8'hFF);
      b_req[0] = 1'b1; b_wen[0] = 1'b0; b_addr[0] = A_MTIME;
      b_req[1] = 1'b1; b_wen[1] = 1'b0; b_addr[1] = A_MTIME;
      step();
      chk("t6_pre_rst_tirp", 64'(tirp0), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      reset_model();
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      rst = 1'b1;

      // Randomised traffic on both instances.
      for (int n = 0; n < 500; n++) begin
         for (int d = 0; d < 2; d++) begin
            case ($urandom_range(0, 5))
               0:       base = A_MSIP;
               1, 2:    base = A_CMP;
               3:       base = A_MTIME;
               4:       base = A_HOLE;
               default: base = 16'($urandom_range(0, 16'hFFFF));
            endcase
            b_req[d]   = ($urandom_range(0, 3) != 0);
            b_wen[d]   = 1'($urandom_range(0, 1));
            b_addr[d]  = base | 16'($urandom_range(0, 7));
            b_wstrb[d] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
               0:       b_wdata[d] = {$urandom, $urandom};
               1:       b_wdata[d] = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
               default: b_wdata[d] = model_mtime(d, k) + 64'($urandom_range(0, 12));
            endcase
         end
         step();
      end
      b_req[0] = 1'b0;
      b_req[1] = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ysyx_040729_clint
